// File: rtl/regfile_write_arbiter.sv
// Two-port register-file writeback arbiter with round-robin contention handling
// and a pending-write (busy) scoreboard for destination registers.
module regfile_write_arbiter #(
  parameter int ADDR_BITS = 3,
  parameter int DATA_BITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req0_valid,
  input  logic [ADDR_BITS-1:0]        req0_addr,
  input  logic [DATA_BITS-1:0]        req0_data,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [ADDR_BITS-1:0]        req1_addr,
  input  logic [DATA_BITS-1:0]        req1_data,
  output logic                        req1_ready,
  input  logic                        rsv_valid,
  input  logic [ADDR_BITS-1:0]        rsv_addr,
  output logic                        wr_enable,
  output logic [ADDR_BITS-1:0]        wr_addr,
  output logic [DATA_BITS-1:0]        wr_data,
  output logic [(2**ADDR_BITS)-1:0]   busy
);

  localparam int NUM_REGS = 2**ADDR_BITS;

  // Handshake: a request is accepted in any cycle where reqN_valid && reqN_ready.
  // ready never depends on ready, and an unaccepted requester holds its inputs.
  logic                last_grant;
  logic                grant0;
  logic                grant1;
  logic                accept;
  logic [NUM_REGS-1:0] busy_next;

  // Round-robin: on contention the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset) begin
      if (req0_valid && (!req1_valid || last_grant)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  // Reservation is applied after the clear so it wins a same-register collision.
  always_comb begin
    busy_next = busy;
    if (wr_enable) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (rsv_valid) begin
      busy_next[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_enable  <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= '0;
      last_grant <= 1'b1;
    end else begin
      wr_enable <= accept;
      busy      <= busy_next;
      if (grant0) begin
        wr_addr    <= req0_addr;
        wr_data    <= req0_data;
        last_grant <= 1'b0;
      end else if (grant1) begin
        wr_addr    <= req1_addr;
        wr_data    <= req1_data;
        last_grant <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by randomized
// traffic, all checked against a rule-level reference model.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid;
  logic [2:0] req0_addr;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [2:0] req1_addr;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       rsv_valid;
  logic [2:0] rsv_addr;
  logic       wr_enable;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] busy;

  regfile_write_arbiter #(.ADDR_BITS(3), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  // Clock / reset block
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: who won the last contention, pending-register set, last write.
  int         m_last = 1;
  bit         m_busy [8];
  logic       m_wr_en = 1'b0;
  logic [2:0] m_wr_addr = '0;
  logic [7:0] m_wr_data = '0;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Driver: one clock cycle of stimulus, with ready checked before the edge
  // and registered outputs checked #1 after it.
  task automatic cycle(input logic r,
                       input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                       input logic rv, input logic [2:0] ra,
                       output logic g0, output logic g1);
    int         w;
    bit         nb [8];
    logic [7:0] eb;
    logic [10:0] item;
    @(negedge clk);
    reset = r;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    rsv_valid = rv; rsv_addr = ra;
    #1;
    w = -1;
    if (r) begin
      if (v0 && !v1)      w = 0;
      else if (v1 && !v0) w = 1;
      else if (v0 && v1)  w = (m_last == 0) ? 1 : 0;
    end
    g0 = (w == 0);
    g1 = (w == 1);
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));

    for (int i = 0; i < 8; i++) begin
      if (!r)                              nb[i] = 1'b0;
      else if (rv && int'(ra) == i)        nb[i] = 1'b1;
      else if (m_wr_en && int'(m_wr_addr) == i) nb[i] = 1'b0;
      else                                 nb[i] = m_busy[i];
    end

    if (!r) begin
      m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0; m_last = 1;
      exp_q.delete();
    end else if (w >= 0) begin
      m_wr_en = 1'b1;
      exp_q.push_back((w == 0) ? {a0, d0} : {a1, d1});
      m_last = w;
    end else begin
      m_wr_en = 1'b0;
    end
    m_busy = nb;

    @(posedge clk);
    #1;
    check("wr_enable", 32'(wr_enable), 32'(m_wr_en));
    if (m_wr_en && exp_q.size() > 0) begin
      item = exp_q.pop_front();
      m_wr_addr = item[10:8];
      m_wr_data = item[7:0];
    end
    check("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
    check("wr_data", 32'(wr_data), 32'(m_wr_data));
    eb = '0;
    for (int i = 0; i < 8; i++) eb[i] = m_busy[i];
    check("busy", 32'(busy), 32'(eb));
  endtask

  task automatic idle(input logic r);
    logic g0, g1;
    cycle(r, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, g0, g1);
  endtask

  logic       g0, g1;
  logic       h0v, h1v;
  logic [2:0] h0a, h1a;
  logic [7:0] h0d, h1d;
  logic       rr, rv;
  logic [2:0] ra;

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
    for (int i = 0; i < 8; i++) m_busy[i] = 1'b0;

    // Reset with live requests and a reservation: all ignored
    cycle(1'b0, 1'b1, 3'd6, 8'hAA, 1'b1, 3'd2, 8'hBB, 1'b1, 3'd3, g0, g1);
    cycle(1'b0, 1'b1, 3'd6, 8'hAA, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, g0, g1);

    // Single request: 1-cycle latency, then wr_enable drops
    cycle(1'b1, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, g0, g1);
    idle(1'b1);

    // Contention from a fresh reset: req0, req1, req0, req1 with no bubble
    idle(1'b0);
    cycle(1'b1, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 3'd0, g0, g1);
    cycle(1'b1, 1'b1, 3'd1, 8'h13, 1'b1, 3'd2, 8'h22, 1'b0, 3'd0, g0, g1);
    cycle(1'b1, 1'b1, 3'd1, 8'h13, 1'b1, 3'd2, 8'h24, 1'b0, 3'd0, g0, g1);
    cycle(1'b1, 1'b1, 3'd1, 8'h15, 1'b1, 3'd2, 8'h24, 1'b0, 3'd0, g0, g1);
    idle(1'b1);

    // Same destination on both ports still round-robins
    cycle(1'b1, 1'b1, 3'd6, 8'h61, 1'b1, 3'd6, 8'h62, 1'b0, 3'd0, g0, g1);
    cycle(1'b1, 1'b1, 3'd6, 8'h63, 1'b1, 3'd6, 8'h62, 1'b0, 3'd0, g0, g1);

    // Scoreboard: reserve 5, load writes 5 two cycles later
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, g0, g1);
    idle(1'b1);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h55, 1'b0, 3'd0, g0, g1);
    idle(1'b1);
    idle(1'b1);

    // Set/clear collision on register 4: reservation wins
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, g0, g1);
    cycle(1'b1, 1'b1, 3'd4, 8'h44, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, g0, g1);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, g0, g1);
    idle(1'b1);
    // Reserving an already-busy register, and writing a non-busy one
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 8'h0E, 1'b1, 3'd4, g0, g1);
    idle(1'b1);

    // Reset mid-operation
    cycle(1'b1, 1'b1, 3'd7, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, g0, g1);
    cycle(1'b0, 1'b1, 3'd2, 8'h12, 1'b1, 3'd3, 8'h13, 1'b1, 3'd7, g0, g1);
    cycle(1'b1, 1'b1, 3'd2, 8'h12, 1'b1, 3'd3, 8'h13, 1'b0, 3'd0, g0, g1);
    idle(1'b1);

    // Randomized traffic; unaccepted requesters hold their inputs
    h0v = 1'b0; h1v = 1'b0; h0a = '0; h1a = '0; h0d = '0; h1d = '0;
    for (int n = 0; n < 400; n++) begin
      if (!h0v) begin
        h0v = 1'($urandom_range(0, 1));
        h0a = 3'($urandom_range(0, 7));
        h0d = 8'($urandom_range(0, 255));
      end
      if (!h1v) begin
        h1v = 1'($urandom_range(0, 1));
        h1a = 3'($urandom_range(0, 7));
        h1d = 8'($urandom_range(0, 255));
      end
      rr = ($urandom_range(0, 39) != 0);
      rv = ($urandom_range(0, 2) == 0);
      ra = 3'($urandom_range(0, 7));
      cycle(rr, h0v, h0a, h0d, h1v, h1a, h1d, rv, ra, g0, g1);
      if (g0) h0v = 1'b0;
      if (g1) h1v = 1'b0;
    end
    idle(1'b1);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default REGISTER_ADDRESS_BITS: register address width; the block SHALL track 2**ADDR_BITS registers.
REQ-002 Parameter DATA_BITS, default REGISTER_DATA_BITS: register data width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req0_valid  input  1  ALU writeback request valid.
REQ-006 req0_addr  input  ADDR_BITS  ALU destination register.
REQ-007 req0_data  input  DATA_BITS  ALU result.
REQ-008 req0_ready  output  1  ALU request accepted this cycle.
REQ-009 req1_valid  input  1  load writeback request valid.
REQ-010 req1_addr  input  ADDR_BITS  load destination register.
REQ-011 req1_data  input  DATA_BITS  load data.
REQ-012 req1_ready  output  1  load request accepted this cycle.
REQ-013 rsv_valid  input  1  issue stage reserves a destination register.
REQ-014 rsv_addr  input  ADDR_BITS  register being reserved.
REQ-015 wr_enable  output  1  register file write enable, registered.
REQ-016 wr_addr  output  ADDR_BITS  register file write address, registered.
REQ-017 wr_data  output  DATA_BITS  register file write data, registered.
REQ-018 busy  output  2**ADDR_BITS  pending-write mask, bit n for register n, registered.

Function
REQ-019 A request SHALL be accepted in a cycle where reqN_valid and reqN_ready are both 1.
REQ-020 reqN_ready SHALL be combinational from the valid inputs and last_grant; it SHALL be 0 when reqN_valid is 0.
REQ-021 At most one of req0_ready and req1_ready SHALL be 1 in any cycle.
REQ-022 Only req0_valid=1: req0_ready=1. Only req1_valid=1: req1_ready=1.
REQ-023 Both valid: the requester not equal to last_grant SHALL be granted (round-robin). This applies even when req0_addr equals req1_addr.
REQ-024 last_grant (1 bit, internal) SHALL update to the granted index on every accept. It SHALL hold when there is no accept.
REQ-025 On accept, wr_enable SHALL be 1 on the next cycle, with wr_addr/wr_data equal to the accepted addr/data. Latency is exactly 1 cycle.
REQ-026 Without accept, wr_enable SHALL be 0 the next cycle; wr_addr/wr_data SHALL hold their previous values.
REQ-027 Back-to-back accepts SHALL produce wr_enable=1 on consecutive cycles with no bubble. Sustained throughput is 1 write/cycle.
REQ-028 rsv_valid=1 SHALL set busy[rsv_addr] at the next edge.
REQ-029 When wr_enable=1, busy[wr_addr] SHALL clear at the next edge.
REQ-030 Simultaneous set and clear of the same bit SHALL leave it set (the reservation wins).
REQ-031 A write to a register whose busy bit is 0 SHALL proceed normally; busy is unaffected.
REQ-032 Reserving an already-busy register SHALL leave it busy; no count is kept.
REQ-033 The block SHALL hold no request buffering; an unaccepted requester keeps its inputs stable until ready.

Reset
REQ-034 While reset=0 at an edge: wr_enable=0, wr_addr=0, wr_data=0, busy=0, last_grant=1 (req0 wins the first contention).
REQ-035 While reset=0, req0_ready and req1_ready SHALL be 0.
REQ-036 A request accepted in the cycle before reset asserts SHALL be dropped; wr_enable SHALL be 0 after the reset edge.
REQ-037 A reservation presented during reset SHALL be ignored.

Verification (DATA_BITS=8, ADDR_BITS=3)
REQ-038 Single request: req0 valid, addr 3, data 0x5A at cycle t -> req0_ready=1 at t; wr_enable=1, wr_addr=3, wr_data=0x5A at t+1; wr_enable=0 at t+2.
REQ-039 Contention:
  - Setup: after reset, both valid for 4 cycles; req0 {1,0x11}, req1 {2,0x22}, each requester's inputs updated after its accept.
  - Required grant order: req0, req1, req0, req1.
  - Required result: wr_enable=1 for 4 consecutive cycles.
REQ-040 Scoreboard:
  - Stimulus: rsv addr 5 at t; req1 writes addr 5 at t+2.
  - Required response: busy=0x20 from t+1; wr_enable at t+3; busy=0x00 at t+4.
REQ-041 Set/clear collision: wr_enable=1 with wr_addr=4, and rsv_valid=1 with rsv_addr=4, in the same cycle -> busy[4]=1 afterwards.
REQ-042 Reset mid-operation:
  - Stimulus: accept req0 {7,0xFF} and rsv addr 7 at t; reset=0 at t+1.
  - Required response: wr_enable=0, busy=0, wr_addr=0, wr_data=0 after the reset edge.
  - After reset: next contention is granted to req0.
